// File: rtl/div_unit_radix2.sv
// Multi-cycle radix-2 restoring divider for MDU DIV/DIVU requests.
// Returns {remainder, quotient}; done is low for DW+1 cycles after each accepted request.
module div_unit_radix2 #(
  parameter  int DW    = 32,
  localparam int CNT_W = $clog2(DW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      div_op,
  input  logic [DW-1:0]   dividend,
  input  logic [DW-1:0]   divisor,
  output logic [2*DW-1:0] result,
  output logic            done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    rem_q;
  logic [DW-1:0]    quo_q;
  logic [DW-1:0]    dvs_q;
  logic [DW-1:0]    dvd_raw_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;
  logic [2*DW-1:0]  result_q;
  logic             done_q;

  logic            is_signed;
  logic            accept;
  logic [DW-1:0]   a_abs;
  logic [DW-1:0]   b_abs;
  logic [DW:0]     rem_sh;
  logic [DW:0]     trial;
  logic [DW-1:0]   quo_fix;
  logic [DW-1:0]   rem_fix;

  assign is_signed = (div_op == 2'b10);
  assign accept    = (state_q == S_IDLE) && ((div_op == 2'b10) || (div_op == 2'b01));
  assign a_abs     = (is_signed && dividend[DW-1]) ? -dividend : dividend;
  assign b_abs     = (is_signed && divisor[DW-1])  ? -divisor  : divisor;

  // rem stays below the divisor, so the DW+1 bit trial difference never overflows.
  assign rem_sh  = {rem_q, quo_q[DW-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            quo_q     <= a_abs;
            rem_q     <= '0;
            dvs_q     <= b_abs;
            dvd_raw_q <= dividend;
            dz_q      <= (divisor == '0);
            q_neg_q   <= is_signed & (dividend[DW-1] ^ divisor[DW-1]);
            r_neg_q   <= is_signed & dividend[DW-1];
            cnt_q     <= '0;
            done_q    <= 1'b0;
            state_q   <= S_CALC;
          end
        end
        S_CALC: begin
          quo_q <= {quo_q[DW-2:0], ~trial[DW]};
          rem_q <= trial[DW] ? rem_sh[DW-1:0] : trial[DW-1:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DW - 1))
            state_q <= S_FIX;
        end
        S_FIX: begin
          // Divide by zero returns the raw dividend, bypassing the sign fix-up.
          result_q <= dz_q ? {dvd_raw_q, {DW{1'b1}}} : {rem_fix, quo_fix};
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
